// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use and ID-resolved branch/JALR hazard
// detection. A hazard holds the PC and IF/ID and sends a bubble into EX.
// A saturating counter records how many cycles the stage stalled.
module id_ex_stage_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              id_valid_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_to_reg_i,
  input  logic              id_mem_write_i,
  input  logic              id_reg_write_i,
  input  logic              id_load_i,
  input  logic              id_store_i,
  input  logic              id_immd_i,
  input  logic              id_jal_i,
  input  logic              id_jalr_i,
  input  logic              id_branch_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_W-1:0]  id_rs1_i,
  input  logic [REG_W-1:0]  id_rs2_i,
  input  logic [REG_W-1:0]  id_rd_i,
  input  logic [2:0]        id_funct3_i,
  input  logic [6:0]        id_funct7_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_W-1:0]  mem_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_load_o,
  output logic              ex_store_o,
  output logic              ex_immd_o,
  output logic              ex_jal_o,
  output logic              ex_jalr_o,
  output logic              ex_branch_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_W-1:0]  ex_rs1_o,
  output logic [REG_W-1:0]  ex_rs2_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic [2:0]        ex_funct3_o,
  output logic [6:0]        ex_funct7_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Everything the EX stage sees, held as one record so a bubble is a single '0.
  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              reg_write;
    logic              load;
    logic              store;
    logic              immd;
    logic              jal;
    logic              jalr;
    logic              branch;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  logic uses_rs1, uses_rs2;
  logic match_ex, match_mem;
  logic hazard_load_use, hazard_id_resolve;

  // Hazard detection: which source registers the ID instruction reads and
  // whether a producer in EX or MEM will not have its value ready in time.
  always_comb begin
    uses_rs1 = (id_reg_write_i | id_store_i | id_branch_i) & ~id_jal_i;
    uses_rs2 = (id_reg_write_i & ~id_immd_i & ~id_jal_i & ~id_jalr_i) |
               id_store_i | id_branch_i;

    match_ex  = (ex_q.rd != '0) &
                ((uses_rs1 & (id_rs1_i == ex_q.rd)) |
                 (uses_rs2 & (id_rs2_i == ex_q.rd)));
    match_mem = (mem_rd_i != '0) &
                ((uses_rs1 & (id_rs1_i == mem_rd_i)) |
                 (uses_rs2 & (id_rs2_i == mem_rd_i)));

    hazard_load_use   = ex_q.valid & ex_q.mem_read & match_ex;
    hazard_id_resolve = (id_branch_i | id_jalr_i) &
                        ((ex_q.valid & ex_q.reg_write & match_ex) |
                         (mem_mem_read_i & match_mem));

    // A flushed instruction never causes a stall: flush takes priority.
    stall_o = id_valid_i & ~flush_i & (hazard_load_use | hazard_id_resolve);
  end

  // Next EX contents: bubble on flush or stall, otherwise capture ID.
  // Control bits of an invalid ID slot are cleared so they cannot act in EX.
  always_comb begin
    ex_d = '0;
    if (!flush_i && !stall_o) begin
      ex_d.valid      = id_valid_i;
      ex_d.mem_read   = id_valid_i & id_mem_read_i;
      ex_d.mem_to_reg = id_valid_i & id_mem_to_reg_i;
      ex_d.mem_write  = id_valid_i & id_mem_write_i;
      ex_d.reg_write  = id_valid_i & id_reg_write_i;
      ex_d.load       = id_valid_i & id_load_i;
      ex_d.store      = id_valid_i & id_store_i;
      ex_d.immd       = id_valid_i & id_immd_i;
      ex_d.jal        = id_valid_i & id_jal_i;
      ex_d.jalr       = id_valid_i & id_jalr_i;
      ex_d.branch     = id_valid_i & id_branch_i;
      ex_d.pc         = id_pc_i;
      ex_d.rs1_data   = id_rs1_data_i;
      ex_d.rs2_data   = id_rs2_data_i;
      ex_d.imm        = id_imm_i;
      ex_d.rs1        = id_rs1_i;
      ex_d.rs2        = id_rs2_i;
      ex_d.rd         = id_rd_i;
      ex_d.funct3     = id_funct3_i;
      ex_d.funct7     = id_funct7_i;
    end
  end

  // Saturating stall counter: counts cycles with stall_o high, sticks at max.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the whole EX record is reset (not just valid) because the
  // data fields are visible on the outputs and must read 0 out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_load_o       = ex_q.load;
  assign ex_store_o      = ex_q.store;
  assign ex_immd_o       = ex_q.immd;
  assign ex_jal_o        = ex_q.jal;
  assign ex_jalr_o       = ex_q.jalr;
  assign ex_branch_o     = ex_q.branch;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rs1_data_o   = ex_q.rs1_data;
  assign ex_rs2_data_o   = ex_q.rs2_data;
  assign ex_imm_o        = ex_q.imm;
  assign ex_rs1_o        = ex_q.rs1;
  assign ex_rs2_o        = ex_q.rs2;
  assign ex_rd_o         = ex_q.rd;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_funct7_o     = ex_q.funct7;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg (stall counter built 4 bits wide so
// saturation is reachable). Expected EX contents are queued when ID is driven
// and popped after the capturing edge.
module tb_id_ex_stage_reg;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // Control-bit order: mem_read, mem_to_reg, mem_write, reg_write, load,
  // store, immd, jal, jalr, branch.
  localparam logic [9:0] C_MEM_READ   = 10'b10_0000_0000;
  localparam logic [9:0] C_MEM_TO_REG = 10'b01_0000_0000;
  localparam logic [9:0] C_REG_WRITE  = 10'b00_0100_0000;
  localparam logic [9:0] C_LOAD       = 10'b00_0010_0000;
  localparam logic [9:0] C_IMMD       = 10'b00_0000_1000;
  localparam logic [9:0] C_JAL        = 10'b00_0000_0100;
  localparam logic [9:0] C_JALR       = 10'b00_0000_0010;
  localparam logic [9:0] C_BRANCH     = 10'b00_0000_0001;

  localparam logic [9:0] OP_LD   = C_MEM_READ | C_MEM_TO_REG | C_REG_WRITE | C_LOAD | C_IMMD;
  localparam logic [9:0] OP_ADD  = C_REG_WRITE;
  localparam logic [9:0] OP_ADDI = C_REG_WRITE | C_IMMD;
  localparam logic [9:0] OP_BEQ  = C_BRANCH;
  localparam logic [9:0] OP_JAL  = C_REG_WRITE | C_JAL | C_IMMD;
  localparam logic [9:0] OP_JALR = C_REG_WRITE | C_JALR | C_IMMD;

  typedef struct packed {
    logic             valid;
    logic [9:0]       ctrl;
    logic [63:0]      pc;
    logic [63:0]      rs1_data;
    logic [63:0]      rs2_data;
    logic [63:0]      imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_ctrl = '0;
  logic [63:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0]  id_funct3 = '0;
  logic [6:0]  id_funct7 = '0;
  logic        mem_mem_read = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        flush = 1'b0;

  logic             stall;
  logic             ex_valid;
  logic [9:0]       ex_ctrl;
  logic [63:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  logic [6:0]       ex_funct7;
  logic [CNT_W-1:0] stall_cnt;
  obs_t             obs_act;

  int   compared   = 0;
  int   mismatched = 0;
  int   cnt_model  = 0;
  obs_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(64), .REG_W(5), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .id_valid_i     (id_valid),
    .id_mem_read_i  (id_ctrl[9]),
    .id_mem_to_reg_i(id_ctrl[8]),
    .id_mem_write_i (id_ctrl[7]),
    .id_reg_write_i (id_ctrl[6]),
    .id_load_i      (id_ctrl[5]),
    .id_store_i     (id_ctrl[4]),
    .id_immd_i      (id_ctrl[3]),
    .id_jal_i       (id_ctrl[2]),
    .id_jalr_i      (id_ctrl[1]),
    .id_branch_i    (id_ctrl[0]),
    .id_pc_i        (id_pc),
    .id_rs1_data_i  (id_rs1_data),
    .id_rs2_data_i  (id_rs2_data),
    .id_imm_i       (id_imm),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rd_i        (id_rd),
    .id_funct3_i    (id_funct3),
    .id_funct7_i    (id_funct7),
    .mem_mem_read_i (mem_mem_read),
    .mem_rd_i       (mem_rd),
    .flush_i        (flush),
    .stall_o        (stall),
    .ex_valid_o     (ex_valid),
    .ex_mem_read_o  (ex_ctrl[9]),
    .ex_mem_to_reg_o(ex_ctrl[8]),
    .ex_mem_write_o (ex_ctrl[7]),
    .ex_reg_write_o (ex_ctrl[6]),
    .ex_load_o      (ex_ctrl[5]),
    .ex_store_o     (ex_ctrl[4]),
    .ex_immd_o      (ex_ctrl[3]),
    .ex_jal_o       (ex_ctrl[2]),
    .ex_jalr_o      (ex_ctrl[1]),
    .ex_branch_o    (ex_ctrl[0]),
    .ex_pc_o        (ex_pc),
    .ex_rs1_data_o  (ex_rs1_data),
    .ex_rs2_data_o  (ex_rs2_data),
    .ex_imm_o       (ex_imm),
    .ex_rs1_o       (ex_rs1),
    .ex_rs2_o       (ex_rs2),
    .ex_rd_o        (ex_rd),
    .ex_funct3_o    (ex_funct3),
    .ex_funct7_o    (ex_funct7),
    .stall_cnt_o    (stall_cnt)
  );

  assign obs_act = {ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                    ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, stall_cnt};

  task automatic check(input string tag, input obs_t act, input obs_t exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_stall(input string tag, input logic exp);
    compared++;
    assert (stall === exp) else begin
      mismatched++;
      $error("FAIL %s stall_o: observed %b expected %b", tag, stall, exp);
    end
  endtask

  // Present one instruction in ID with fresh random data fields.
  task automatic set_id(input logic v, input logic [9:0] c,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid    = v;
    id_ctrl     = c;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_pc       = {$urandom, $urandom};
    id_rs1_data = {$urandom, $urandom};
    id_rs2_data = {$urandom, $urandom};
    id_imm      = {$urandom, $urandom};
    id_funct3   = 3'($urandom_range(0, 7));
    id_funct7   = 7'($urandom_range(0, 127));
  endtask

  // One cycle: check stall_o against the directed expectation, queue the
  // expected EX record, clock, then pop and compare.
  task automatic step(input string tag, input logic exp_stall);
    obs_t e;
    #1;
    check_stall(tag, exp_stall);
    e = '0;
    if (!flush && !exp_stall) begin
      e.valid    = id_valid;
      e.ctrl     = id_valid ? id_ctrl : 10'b0;
      e.pc       = id_pc;
      e.rs1_data = id_rs1_data;
      e.rs2_data = id_rs2_data;
      e.imm      = id_imm;
      e.rs1      = id_rs1;
      e.rs2      = id_rs2;
      e.rd       = id_rd;
      e.funct3   = id_funct3;
      e.funct7   = id_funct7;
    end
    if (exp_stall && cnt_model < CNT_MAX) cnt_model++;
    e.cnt = CNT_W'(cnt_model);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, obs_act, e);
  endtask

  initial begin
    // Reset state.
    #12;
    check("reset_state", obs_act, '0);
    check_stall("reset_state", 1'b0);
    reset_n = 1'b1;

    // Load-use: ld x5 ; add x6,x5,x1 -> one stall, bubble, then add.
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd5);
    step("lu_ld", 1'b0);
    set_id(1'b1, OP_ADD, 5'd5, 5'd1, 5'd6);
    step("lu_stall", 1'b1);
    mem_mem_read = 1'b1; mem_rd = 5'd5;   // ld now in MEM; ALU op ignores it
    step("lu_add", 1'b0);
    mem_mem_read = 1'b0; mem_rd = 5'd0;

    // Branch after load: ld x7 ; beq x7,x0 -> two stalls.
    set_id(1'b1, OP_LD, 5'd3, 5'd0, 5'd7);
    step("bl_ld", 1'b0);
    set_id(1'b1, OP_BEQ, 5'd7, 5'd0, 5'd0);
    step("bl_stall_ex", 1'b1);
    mem_mem_read = 1'b1; mem_rd = 5'd7;
    step("bl_stall_mem", 1'b1);
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    step("bl_beq", 1'b0);

    // ALU op followed by dependent branch and JALR: one stall each.
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd8);
    step("ab_add", 1'b0);
    set_id(1'b1, OP_BEQ, 5'd4, 5'd8, 5'd0);
    step("ab_stall", 1'b1);
    step("ab_beq", 1'b0);
    set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd9);
    step("aj_add", 1'b0);
    set_id(1'b1, OP_JALR, 5'd9, 5'd9, 5'd1);
    step("aj_stall", 1'b1);
    step("aj_jalr", 1'b0);

    // x0 destination and unused operands never stall.
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd0);
    step("x0_ld", 1'b0);
    set_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd1);
    step("x0_add", 1'b0);
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd5);
    step("imm_ld", 1'b0);
    set_id(1'b1, OP_ADDI, 5'd1, 5'd5, 5'd6);
    step("imm_addi", 1'b0);
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd5);
    step("jal_ld", 1'b0);
    set_id(1'b1, OP_JAL, 5'd5, 5'd5, 5'd1);
    step("jal_jal", 1'b0);

    // Flush beats a load-use hazard: no stall, bubble, counter unchanged.
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd5);
    step("fl_ld", 1'b0);
    set_id(1'b1, OP_ADD, 5'd5, 5'd1, 5'd6);
    flush = 1'b1;
    step("fl_flush", 1'b0);
    flush = 1'b0;

    // Invalid ID slot: control cleared, data still captured; never stalls.
    set_id(1'b0, OP_LD, 5'd2, 5'd0, 5'd5);
    step("inv_ld", 1'b0);
    set_id(1'b1, OP_ADD, 5'd5, 5'd1, 5'd6);
    step("inv_add", 1'b0);

    // Asynchronous reset while EX holds a valid instruction.
    #2;
    reset_n = 1'b0;
    #1;
    cnt_model = 0;
    check("async_reset", obs_act, '0);
    #1;
    reset_n = 1'b1;

    // Reset in the middle of a stall: restart from an empty EX.
    set_id(1'b1, OP_LD, 5'd2, 5'd0, 5'd5);
    step("rs_ld", 1'b0);
    set_id(1'b1, OP_ADD, 5'd5, 5'd1, 5'd6);
    #1;
    check_stall("rs_pre", 1'b1);
    reset_n = 1'b0;
    #1;
    check_stall("rs_in_reset", 1'b0);
    check("rs_cleared", obs_act, '0);
    reset_n = 1'b1;
    step("rs_add", 1'b0);

    // Hold a MEM-load hazard on a branch for 20 cycles: counter saturates.
    mem_mem_read = 1'b1; mem_rd = 5'd7;
    set_id(1'b1, OP_BEQ, 5'd7, 5'd0, 5'd0);
    for (int i = 0; i < 20; i++) step("sat", 1'b1);
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    set_id(1'b0, 10'b0, 5'd0, 5'd0, 5'd0);
    step("sat_hold", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
